pipe_rr_arbiter: RTL and testbench
==================================

# pipe_rr_arbiter

Round-robin arbiter that shares one registered valid/ready output stage among N requesters. Each requester presents a 16-bit beat with a last flag. The arbiter picks one winner per cycle and loads the winner's beat into an internal output register built like our standard pipe stage. It sits upstream of any single-consumer datapath that several producers must feed, and sustains one beat per cycle under continuous `out_rdy`.

## Interface
- `N`, 4: number of requesters, 2..8.
- `DW`, 16: data width.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_vld`  in  N  per-requester valid.
- `in_rdy`  out  N  per-requester ready; one-hot or zero.
- `in_data`  in  N*DW  requester i on bits [i*DW +: DW].
- `in_last`  in  N  per-requester last-beat flag.
- `out_vld`  out  1  output register holds a beat.
- `out_rdy`  in  1  downstream ready.
- `out_data`  out  DW  registered beat.
- `out_last`  out  1  registered last flag.
- `out_src`  out  max(1,$clog2(N))  index of the requester that supplied the current beat.

## Operation
- Load enable: `ld = ~out_vld | out_rdy`. It is combinational from `out_rdy`, which is the only combinational path to `in_rdy`.
- Priority pointer `ptr` (0..N-1). Search order: ptr, ptr+1, … wrapping mod N. The first requester with `in_vld`=1 wins (`gnt`, one-hot).
- `in_rdy[i] = gnt[i] & ld`. A transfer happens on requester i when `in_vld[i] & in_rdy[i]`; at most one i per cycle.
- On a transfer from i:
  - `out_data`/`out_last`/`out_src` are loaded with i's beat.
  - `out_vld` <= 1.
  - `ptr` <= (i+1) mod N, subject to the lock rules below.
- When `ld`=1 and there is no transfer: `out_vld` <= 0. Data, last and src hold.
- When `ld`=0: all output registers hold and `ptr` holds.
- `in_rdy` never asserts for a requester with `in_vld`=0, so `gnt` is zero when no input is valid.
- Reset values: `out_vld`=0, `out_data`=0, `out_last`=0, `out_src`=0, `ptr`=0, lock state UNLOCKED. Reset mid-burst discards the held beat and the lock.

## Timing
- Latency: 1 cycle. A beat accepted at edge k appears on `out_*` after edge k.
- Throughput: 1 beat/cycle while `out_rdy`=1. There are no bubbles on a source switch.
- Backpressure: `out_vld`=1 with `out_rdy`=0 holds `out_*` stable and forces all `in_rdy`=0.
- Fairness: with all N requesters continuously valid and lock off, grants rotate 0,1,…,N-1,0. Each requester waits at most N-1 beats.
- If the winner drops `in_vld` before its transfer, the arbiter re-evaluates the next cycle. No grant is remembered while unaccepted.

## Configuration
- Macro `PIPE_RR_ARB_LOCK_EN`.
- Defined, the burst-lock FSM is compiled in:
  - States: UNLOCKED, LOCKED(src).
  - UNLOCKED → LOCKED(i) on a transfer from i with `in_last`=0. `ptr` is not advanced.
  - In LOCKED(i), only i may be granted. Others wait even if i is idle, and `ptr` holds.
  - LOCKED(i) → UNLOCKED on a transfer from i with `in_last`=1, with `ptr` <= (i+1) mod N.
  - A single-beat burst (`in_last`=1 on the first beat) never locks.
- Undefined: no lock state. `in_last` is passed through to `out_last` only, and arbitration rotates every beat.

## Test plan
- Reset: assert `rst_n`=0 mid-traffic → `out_vld`=0, `out_data`=0x0000, `out_src`=0, `in_rdy`=0 immediately. After release, requester 0 wins first.
- Single requester: only req 2 valid with 0x1111, 0x2222, 0x3333 and `out_rdy`=1 → beats appear back-to-back one cycle later, `out_src`=2, `in_rdy[2]`=1 every cycle.
- Full contention, N=4, all valid, `out_rdy`=1, lock off (each beat `in_last`=1) → `out_src` sequence 0,1,2,3,0,1 with no idle cycles.
- Backpressure: hold `out_rdy`=0 for 5 cycles with `out_vld`=1 and data 0xABCD → `out_data` stays 0xABCD, all `in_rdy`=0, `ptr` unchanged. On release the next source loads in the same cycle.
- Burst lock (macro defined): req 1 sends 3 beats (`in_last`=0,0,1) while req 0 and req 3 are valid → `out_src`=1,1,1, then 3, then 0. Insert a one-cycle `in_vld[1]` gap mid-burst → no other source is granted during the gap.
- Same burst stimulus, macro undefined → `out_src` interleaves 1,3,0,1,3,…

Source files
------------

// File: rtl/pipe_rr_arbiter_if.sv
// Requester/consumer bundle for pipe_rr_arbiter: N beat inputs, one registered beat output.
// The slave modport is the arbiter's view; the master modport is the producer/consumer view.
interface pipe_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    in_vld;
  logic [N-1:0]    in_rdy;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic            out_vld;
  logic            out_rdy;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [SW-1:0]   out_src;

  modport slave (
    input  in_vld, in_data, in_last, out_rdy,
    output in_rdy, out_vld, out_data, out_last, out_src
  );

  modport master (
    output in_vld, in_data, in_last, out_rdy,
    input  in_rdy, out_vld, out_data, out_last, out_src
  );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// Round-robin N:1 arbiter feeding one registered output stage; optional burst lock via PIPE_RR_ARB_LOCK_EN.
// Latency 1 cycle, 1 beat/cycle; out_rdy=0 with a held beat forces every in_rdy low.
module pipe_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_rr_arbiter_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic          out_vld_q,  out_vld_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [SW-1:0] out_src_q,  out_src_d;
  logic [SW-1:0] ptr_q,      ptr_d;

  logic [N-1:0]  elig;
  logic [N-1:0]  gnt;
  logic [SW-1:0] win;
  logic [SW-1:0] nxt;
  logic [SW:0]   cand;
  logic          found;
  logic          ld;
  logic          xfer;

`ifdef PIPE_RR_ARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  lock_e         lock_q,     lock_d;
  logic [SW-1:0] lock_src_q, lock_src_d;
`endif

  always_comb begin
    elig = bus.in_vld;
`ifdef PIPE_RR_ARB_LOCK_EN
    // While a burst is open only its owner is eligible, even when it is idle.
    if (lock_q == LOCKED) begin
      elig             = '0;
      elig[lock_src_q] = bus.in_vld[lock_src_q];
    end
`endif
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (SW+1)'(k);
      if (cand >= (SW+1)'(N)) cand = cand - (SW+1)'(N);
      if (!found && elig[cand[SW-1:0]]) begin
        found = 1'b1;
        win   = cand[SW-1:0];
      end
    end
    gnt[win] = found;
  end

  assign ld   = ~out_vld_q | bus.out_rdy;
  assign xfer = found & ld;
  assign nxt  = (win == SW'(N-1)) ? '0 : win + 1'b1;

  // rst_n gate keeps in_rdy low while reset is held, when ld alone would be 1.
  assign bus.in_rdy   = gnt & {N{ld & rst_n}};
  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.out_last = out_last_q;
  assign bus.out_src  = out_src_q;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_src_d  = out_src_q;
    ptr_d      = ptr_q;
    if (ld) out_vld_d = xfer;
    if (xfer) begin
      out_data_d = bus.in_data[win*DW +: DW];
      out_last_d = bus.in_last[win];
      out_src_d  = win;
    end
`ifdef PIPE_RR_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (xfer) begin
      if (lock_q == UNLOCKED) begin
        if (!bus.in_last[win]) begin
          lock_d     = LOCKED;
          lock_src_d = win;
        end else begin
          ptr_d = nxt;
        end
      end else if (bus.in_last[win]) begin
        lock_d = UNLOCKED;
        ptr_d  = nxt;
      end
    end
`else
    if (xfer) ptr_d = nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_src_q  <= '0;
      ptr_q      <= '0;
`ifdef PIPE_RR_ARB_LOCK_EN
      lock_q     <= UNLOCKED;
      lock_src_q <= '0;
`endif
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_src_q  <= out_src_d;
      ptr_q      <= ptr_d;
`ifdef PIPE_RR_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
`endif
    end
  end
endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Bench for pipe_rr_arbiter (N=4): per-cycle vector tables with hand-derived grants,
// plus a beat scoreboard filled on expected transfers and drained on out_vld & out_rdy.
module tb_pipe_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_rr_arbiter_if #(.N(N), .DW(DW)) bus ();

  pipe_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic        ordy;
    logic [15:0] dat;
    logic [3:0]  exp_rdy;
    logic        exp_ovld;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic [1:0]  s;
  } beat_t;

  beat_t       sb[$];
  vec_t        tbl[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          seq     = 0;
  logic        hold_chk = 1'b0;
  logic [15:0] hold_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus; checks at the falling edge, returns 1 time unit after the rising edge.
  task automatic step(input vec_t v);
    beat_t b;
    bus.in_vld  = v.vld;
    bus.in_last = v.last;
    bus.out_rdy = v.ordy;
    for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = v.dat + 16'(i << 12);
    @(negedge clk);
    chk("out_vld", 32'(bus.out_vld), 32'(v.exp_ovld));
    if (bus.out_vld && bus.out_rdy) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got src %0d data 0x%0h, required no beat", bus.out_src, bus.out_data);
      end else begin
        b = sb.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(b.d));
        chk("out_last", 32'(bus.out_last), 32'(b.l));
        chk("out_src",  32'(bus.out_src),  32'(b.s));
      end
    end
    if (hold_chk) chk("hold_data", 32'(bus.out_data), 32'(hold_val));
    chk("in_rdy", 32'(bus.in_rdy), 32'(v.exp_rdy));
    for (int i = 0; i < N; i++)
      if (v.exp_rdy[i]) sb.push_back('{v.dat + 16'(i << 12), v.last[i], 2'(i)});
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] vld, input logic [3:0] last, input logic ordy,
                     input logic [3:0] er, input logic eo);
    seq++;
    tbl.push_back('{vld, last, ordy, 16'(seq * 7 + 16'h0100), er, eo});
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.in_vld  = '0;
    bus.in_last = '0;
    bus.out_rdy = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t v;

  initial begin
    // Reset state with every requester valid: in_rdy must still be 0.
    bus.in_vld  = 4'b1111;
    bus.in_last = 4'b1111;
    bus.in_data = '0;
    bus.out_rdy = 1'b1;
    #3;
    chk("rst_out_vld",  32'(bus.out_vld),  32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_src",  32'(bus.out_src),  32'd0);
    chk("rst_in_rdy",   32'(bus.in_rdy),   32'd0);
    do_reset();

    // Single requester 2, back to back.
    add(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0);
    add(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1);
    add(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    run_tbl("single");

    // Full contention: 0,1,2,3,0,1 with no idle cycles.
    do_reset();
    add(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    add(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1);
    add(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1);
    add(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1);
    add(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1);
    add(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    run_tbl("rotate");

    // Backpressure: 0xABCD held for 5 cycles, then requester 1 loads on release.
    do_reset();
    v = '{4'b0001, 4'b0001, 1'b1, 16'hABCD, 4'b0001, 1'b0};
    step(v);
    hold_chk = 1'b1;
    hold_val = 16'hABCD;
    for (int c = 0; c < 5; c++) begin
      v = '{4'b1111, 4'b1111, 1'b0, 16'h5000 + 16'(c), 4'b0000, 1'b1};
      step(v);
    end
    hold_chk = 1'b0;
    v = '{4'b1111, 4'b1111, 1'b1, 16'h0E00, 4'b0010, 1'b1};
    step(v);
    v = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 1'b1};
    step(v);
    v = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 1'b0};
    step(v);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Burst from 1 (last on 4th cycle, vld gap on 3rd) while 0 and 3 stay valid.
    do_reset();
    add(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0);
`ifdef PIPE_RR_ARB_LOCK_EN
    add(4'b1011, 4'b1001, 1'b1, 4'b0010, 1'b1);
    add(4'b1011, 4'b1001, 1'b1, 4'b0010, 1'b1);
    add(4'b1001, 4'b1001, 1'b1, 4'b0000, 1'b1);
    add(4'b1011, 4'b1011, 1'b1, 4'b0010, 1'b0);
    add(4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1);
    add(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1);
`else
    add(4'b1011, 4'b1001, 1'b1, 4'b0010, 1'b1);
    add(4'b1011, 4'b1001, 1'b1, 4'b1000, 1'b1);
    add(4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1);
    add(4'b1011, 4'b1011, 1'b1, 4'b0010, 1'b1);
    add(4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1);
    add(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1);
`endif
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    run_tbl("burst");

    // Reset mid-traffic, then requester 0 wins first.
    do_reset();
    add(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    add(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1);
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_vld",  32'(bus.out_vld),  32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    chk("midrst_out_src",  32'(bus.out_src),  32'd0);
    chk("midrst_in_rdy",   32'(bus.in_rdy),   32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    add(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    run_tbl("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
